// File: rtl/seg_scan_if.sv
// Signal bundle between the stored-time source and the multiplexed 7-segment scanner.
// The master side supplies the digits and display controls. The slave side drives the display.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 6
);
  logic [4*NUM_DIGITS-1:0] bcd_time;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blank_lead;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output bcd_time, blink_mask, blank_lead,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  bcd_time, blink_mask, blank_lead,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Common-anode 7-segment scanner for HH:MM:SS. It snapshots the time once per frame,
// blanks the start of each digit slot, and supports per-digit blink and leading-zero suppression.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  seg_scan_if.slave   bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SW = 4 * NUM_DIGITS;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low. Non-BCD values show a dash.
  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    logic [6:0] pat;
    case (v)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  logic [CW-1:0]         cnt_r, cnt_nxt_s;
  logic [IW-1:0]         idx_r, idx_nxt_s;
  logic [FW-1:0]         frame_cnt_r, frame_cnt_nxt_s;
  logic                  blink_phase_r, blink_phase_nxt_s;
  logic [SW-1:0]         shadow_r, shadow_nxt_s;
  logic                  load_pending_r;
  logic [6:0]            seg_r, seg_s;
  logic                  dp_r, dp_s;
  logic [NUM_DIGITS-1:0] an_r, an_s;
  logic                  frame_done_r;
  logic                  slot_end_s, last_digit_s, frame_end_s;
  logic [3:0]            digit_s;
  logic                  blank_s;

  assign slot_end_s   = (cnt_r == CW'(REFRESH_DIV - 1));
  assign last_digit_s = (idx_r == IW'(NUM_DIGITS - 1));
  assign frame_end_s  = slot_end_s && last_digit_s;

  // Next scan position, blink timing and frame snapshot
  always_comb begin
    cnt_nxt_s         = cnt_r;
    idx_nxt_s         = idx_r;
    frame_cnt_nxt_s   = frame_cnt_r;
    blink_phase_nxt_s = blink_phase_r;
    shadow_nxt_s      = shadow_r;
    if (slot_end_s) begin
      cnt_nxt_s = '0;
      if (last_digit_s) begin
        idx_nxt_s = '0;
      end else begin
        idx_nxt_s = idx_r + IW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
    if (frame_end_s) begin
      shadow_nxt_s = bus.bcd_time;
      if (frame_cnt_r == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_nxt_s   = '0;
        blink_phase_nxt_s = ~blink_phase_r;
      end else begin
        frame_cnt_nxt_s = frame_cnt_r + FW'(1);
      end
    end else if (load_pending_r) begin
      shadow_nxt_s = bus.bcd_time;
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // Display image for the current slot. Blink and lead control are sampled live.
  always_comb begin
    digit_s = shadow_r[{idx_r, 2'b00} +: 4];
    blank_s = (int'(cnt_r) < BLANK_CYCLES)
           || (bus.blink_mask[idx_r] && blink_phase_r)
           || (bus.blank_lead && (int'(idx_r) == 5) && (digit_s == 4'd0));
    an_s  = '1;
    seg_s = 7'b1111111;
    dp_s  = 1'b1;
    if (blank_s) begin
      an_s  = '1;
      seg_s = 7'b1111111;
      dp_s  = 1'b1;
    end else begin
      an_s[idx_r] = 1'b0;
      seg_s       = seg_encode(digit_s);
      dp_s        = !((int'(idx_r) == 2) || (int'(idx_r) == 4));
    end
  end

  // State and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r          <= '0;
      idx_r          <= '0;
      frame_cnt_r    <= '0;
      blink_phase_r  <= 1'b0;
      shadow_r       <= '0;
      load_pending_r <= 1'b1;
      an_r           <= '1;
      seg_r          <= 7'b1111111;
      dp_r           <= 1'b1;
      frame_done_r   <= 1'b0;
    end else begin
      cnt_r          <= cnt_nxt_s;
      idx_r          <= idx_nxt_s;
      frame_cnt_r    <= frame_cnt_nxt_s;
      blink_phase_r  <= blink_phase_nxt_s;
      shadow_r       <= shadow_nxt_s;
      load_pending_r <= 1'b0;
      an_r           <= an_s;
      seg_r          <= seg_s;
      dp_r           <= dp_s;
      frame_done_r   <= frame_end_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver.
// The reference model derives the expected display from absolute cycle count since reset release.
module tb_seg_scan_driver;
  localparam int N  = 6;
  localparam int R  = 4;
  localparam int BL = 1;
  localparam int BF = 2;
  localparam int FR = R * N;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  int k = 0;
  logic [23:0] snap = 24'h0;

  seg_scan_if #(.NUM_DIGITS(N)) ifc ();

  seg_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic check_blank(input string tag);
    check_val({tag, "_an"}, 32'(ifc.an), 32'h3f);
    check_val({tag, "_seg"}, 32'(ifc.seg), 32'h7f);
    check_val({tag, "_dp"}, 32'(ifc.dp), 32'h1);
    check_val({tag, "_fd"}, 32'(ifc.frame_done), 32'h0);
  endtask

  // Advance one clock and compare against the display the state before this edge should produce.
  task automatic step();
    int s, cnt, idx, f;
    logic ph, blank, e_dp, e_fd;
    logic [3:0] v;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    @(posedge clk);
    k++;
    s   = k - 1;
    cnt = s % R;
    idx = (s / R) % N;
    f   = s / FR;
    ph  = ((f / BF) % 2) == 1;
    v   = 4'((snap >> (4 * idx)) & 24'hF);
    blank = (cnt < BL) || (ifc.blink_mask[idx] && ph) || (ifc.blank_lead && idx == 5 && v == 4'd0);
    e_an  = 6'b111111;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    if (!blank) begin
      e_an[idx] = 1'b0;
      e_seg     = SEG_TAB[v];
      e_dp      = !(idx == 2 || idx == 4);
    end
    e_fd = (s % FR) == FR - 1;
    #1;
    check_val("an", 32'(ifc.an), 32'(e_an));
    check_val("seg", 32'(ifc.seg), 32'(e_seg));
    check_val("dp", 32'(ifc.dp), 32'(e_dp));
    check_val("frame_done", 32'(ifc.frame_done), 32'(e_fd));
    if (k == 1 || (k % FR) == 0) snap = ifc.bcd_time;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    k     = 0;
    snap  = 24'h0;
  endtask

  initial begin
    ifc.bcd_time   = 24'h123456;
    ifc.blink_mask = 6'b000000;
    ifc.blank_lead = 1'b0;
    #2 reset = 1'b0;
    #1 check_blank("reset_async");
    repeat (3) @(posedge clk);
    #1 check_blank("reset_hold");
    release_reset();

    // Basic scan of 0x123456
    run(3 * FR);

    // Mid-frame change must wait for the frame end
    for (int i = 0; i < FR && (k % FR) != 10; i++) step();
    ifc.bcd_time = 24'h000000;
    run(2 * FR);

    // Leading-zero suppression
    ifc.blank_lead = 1'b1;
    ifc.bcd_time   = 24'h095959;
    run(2 * FR);
    ifc.bcd_time = 24'h195959;
    run(2 * FR);
    ifc.blank_lead = 1'b0;

    // Blink on the seconds digits
    ifc.blink_mask = 6'b000011;
    run(8 * FR);
    ifc.blink_mask = 6'b000000;

    // Non-BCD digit shows a dash
    ifc.bcd_time = 24'h12A456;
    run(2 * FR);

    // Random inputs, changed at random cycles
    for (int i = 0; i < 20 * FR; i++) begin
      if ($urandom_range(0, 15) == 0) ifc.bcd_time = 24'($urandom);
      if ($urandom_range(0, 31) == 0) ifc.blink_mask = 6'($urandom);
      if ($urandom_range(0, 31) == 0) ifc.blank_lead = 1'($urandom);
      step();
    end

    // Reset in the middle of a lit slot on digit 3
    for (int i = 0; i < FR && !(((k / R) % N) == 3 && (k % R) == 2); i++) step();
    check_val("pre_reset_an", 32'(ifc.an), 32'h37);
    reset = 1'b0;
    #1 check_blank("reset_mid");
    ifc.bcd_time   = 24'h235958;
    ifc.blink_mask = 6'b000000;
    ifc.blank_lead = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_blank("reset_mid_hold");
    release_reset();
    run(3 * FR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed 7‑segment display driver for the digital clock: reads the six BCD time digits (HH:MM:SS) held by the counter/flip‑flop chain and scans them onto a common‑anode display one digit at a time. It sits at the output end of the design, consuming stored time and never writing it. Per‑frame snapshotting gives a coherent image, anti‑ghost blanking separates digit slots, and a blink facility serves time‑set mode.

## Interface
- `NUM_DIGITS`, 6: digits scanned; index 0 = seconds units … 5 = hours tens.
- `REFRESH_DIV`, 1000: clk cycles per digit slot (≥2).
- `BLANK_CYCLES`, 8: cycles at slot start with all anodes off (< REFRESH_DIV).
- `BLINK_FRAMES`, 64: frames per blink half‑period (≥1).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active‑low reset.
- `bcd_time`  in  4·NUM_DIGITS  BCD digits; digit i at bits [4i+3:4i].
- `blink_mask`  in  NUM_DIGITS  1 = digit i blinks.
- `blank_lead`  in  1  1 = suppress digit 5 when its value is 0.
- `seg`  out  7  {g,f,e,d,c,b,a}, active‑low.
- `dp`  out  1  decimal point, active‑low.
- `an`  out  NUM_DIGITS  digit enables, active‑low, one‑hot‑low or all high.
- `frame_done`  out  1  one‑cycle pulse at end of each full scan.

## Operation
- State: slot counter `cnt` (0..REFRESH_DIV‑1), digit index `idx` (0..NUM_DIGITS‑1), frame counter (0..BLINK_FRAMES‑1), `blink_phase`, shadow register `shadow` (width of bcd_time), `load_pending` flag.
- `cnt` increments every cycle; at REFRESH_DIV‑1 wraps to 0 and `idx` increments, wrapping NUM_DIGITS‑1 → 0.
- Frame end = edge where cnt==REFRESH_DIV‑1 and idx==NUM_DIGITS‑1: `shadow` ← `bcd_time`; frame counter increments; at BLINK_FRAMES‑1 it wraps and `blink_phase` toggles.
- `load_pending` set by reset; first edge after reset release loads `shadow` ← `bcd_time` and clears it. Otherwise `shadow` changes only at frame end.
- Digit value v = shadow[4·idx+3:4·idx]. Encoding: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000; v>9 → 0111111 (dash, g only).
- Digit blanked (an all high, seg 1111111, dp 1) when: cnt < BLANK_CYCLES; or blink_mask[idx]=1 and blink_phase=1; or blank_lead=1, idx=5, v=0.
- Otherwise an[idx]=0, others 1; seg = encoding of v; dp=0 when idx is 2 or 4, else 1.
- `blink_mask`, `blank_lead` sampled live (not shadowed).

## Timing
- All outputs registered: reflect state of previous cycle (1‑cycle latency from cnt/idx to an/seg).
- Reset (asserted, async): cnt=0, idx=0, frame counter=0, blink_phase=0, shadow=0, load_pending=1; an=all 1, seg=1111111, dp=1, frame_done=0.
- `frame_done` high for exactly the cycle after a frame‑end edge.
- bcd_time → display latency: ≤ one frame (NUM_DIGITS·REFRESH_DIV cycles) + 1.
- Mid‑frame bcd_time changes never appear until next frame end (no torn digits).
- Reset mid‑scan: outputs blank immediately (async); scan restarts at idx 0, cnt 0.
- Digit i lit for REFRESH_DIV‑BLANK_CYCLES cycles per frame; never two anodes low simultaneously.

## Test plan
- Params REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2; release reset with bcd_time=0x123456 → digit 0 shows 6 (seg 0000010) on an=111110 for 3 cycles after 1 blank cycle; digit 5 shows 1; dp low only on idx 2, 4; frame_done every 24 cycles.
- Change bcd_time to 0x000000 at cycle 10 of a frame → display keeps 0x123456 until frame end, then shows 0 on all digits.
- blank_lead=1, bcd_time=0x095959 → idx 5 fully blank; set to 0x195959 → idx 5 shows 1 next frame.
- blink_mask=6'b000011, others stable → digits 0,1 lit 2 frames, blank 2 frames, repeating; digits 2–5 always lit.
- bcd_time digit 3 = 0xA → seg 0111111 on idx 3.
- Assert reset mid‑slot at idx 3 → an=111111, seg=1111111 same cycle; after release scan restarts idx 0 with fresh snapshot.
